// File: rtl/score_issue_pkg.sv
// Shared attention-row types: score, V row and the issued tuple.
// `MAX_SEQ_LENGTH falls back to 8 when the build does not set it.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package score_issue_pkg;

  typedef logic signed [15:0] EXPMUL_DIFF_IN_QT;
  typedef logic [3:0][7:0] V_VECTOR_T;

  typedef struct packed {
    EXPMUL_DIFF_IN_QT s;
    EXPMUL_DIFF_IN_QT m_prev;
    V_VECTOR_T        v;
    logic             first;
    logic             last;
  } ISSUE_TUPLE_T;

  function automatic EXPMUL_DIFF_IN_QT smax(
    input EXPMUL_DIFF_IN_QT a,
    input EXPMUL_DIFF_IN_QT b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/score_issue_if.sv
// Score-issue bus: QK-side input handshake and max-stage output
// handshake. slave is the issue stage, master the surrounding pipe.
interface score_issue_if;
  import score_issue_pkg::*;

  logic             vld_in;
  logic             rdy_out;
  EXPMUL_DIFF_IN_QT s_in;
  V_VECTOR_T        v_in;
  logic             vld_out;
  logic             rdy_in;
  EXPMUL_DIFF_IN_QT s_out;
  EXPMUL_DIFF_IN_QT m_prev_out;
  V_VECTOR_T        v_out;
  logic             first_out;
  logic             last_out;
  logic             row_done;

  modport slave (
    input  vld_in, s_in, v_in, rdy_in,
    output rdy_out, vld_out, s_out, m_prev_out,
    output v_out, first_out, last_out, row_done
  );

  modport master (
    output vld_in, s_in, v_in, rdy_in,
    input  rdy_out, vld_out, s_out, m_prev_out,
    input  v_out, first_out, last_out, row_done
  );

endinterface

// File: rtl/score_issue_skid.sv
// issue_skid: 1-entry pipe register, or 2-entry FIFO elastic buffer
// with a registered ready when SCORE_ISSUE_SKID_EN is defined.
module issue_skid
  import score_issue_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         i_vld,
  output logic         o_rdy,
  input  ISSUE_TUPLE_T i_data,
  output logic         o_vld,
  input  logic         i_rdy,
  output ISSUE_TUPLE_T o_data
);

  ISSUE_TUPLE_T r_out;
  logic         r_out_vld;
  logic         w_in_hs;
  logic         w_out_hs;

  assign w_in_hs  = i_vld && o_rdy;
  assign w_out_hs = r_out_vld && i_rdy;
  assign o_vld    = r_out_vld;
  assign o_data   = r_out;

`ifdef SCORE_ISSUE_SKID_EN
  ISSUE_TUPLE_T r_skid;
  logic         r_skid_vld;

  assign o_rdy = !r_skid_vld;

  // Skid only fills while the head is stalled; it drains first.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || w_out_hs) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_in_hs;
        if (w_in_hs) r_out <= i_data;
      end
    end else if (w_in_hs) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
    end
  end
`else
  assign o_rdy = i_rdy || !r_out_vld;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_in_hs) begin
      r_out     <= i_data;
      r_out_vld <= 1'b1;
    end else if (w_out_hs) begin
      r_out_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/score_issue.sv
// Issue stage ahead of the running-max stage; owns key count and m_run.
// Optional output skid buffer: define SCORE_ISSUE_SKID_EN.
module score_issue
  import score_issue_pkg::*;
#(
  parameter int SEQ_LEN = `MAX_SEQ_LENGTH
) (
  input  logic        clock,
  input  logic        reset,
  score_issue_if.slave bus
);

  localparam int CW = $clog2(SEQ_LEN);
  localparam logic [CW-1:0] LAST_KEY = CW'(SEQ_LEN - 1);

  logic [CW-1:0]    r_key_cnt;
  EXPMUL_DIFF_IN_QT r_m_run;
  logic             w_in_hs;
  logic             w_first;
  logic             w_last;
  EXPMUL_DIFF_IN_QT w_m_base;
  ISSUE_TUPLE_T     w_tuple;
  ISSUE_TUPLE_T     w_out;

  assign w_in_hs  = bus.vld_in && bus.rdy_out;
  assign w_first  = (r_key_cnt == '0);
  assign w_last   = (r_key_cnt == LAST_KEY);
  // Row start uses key_cnt, never a stale m_run from the prior row.
  assign w_m_base = w_first ? '0 : r_m_run;

  assign w_tuple = '{
    s:      bus.s_in,
    m_prev: w_m_base,
    v:      bus.v_in,
    first:  w_first,
    last:   w_last
  };

  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_cnt <= '0;
      r_m_run   <= '0;
    end else if (w_in_hs) begin
      r_key_cnt <= w_last ? '0 : r_key_cnt + 1'b1;
      r_m_run   <= smax(bus.s_in, w_m_base);
    end
  end

  issue_skid u_skid (
    .clock  (clock),
    .reset  (reset),
    .i_vld  (bus.vld_in),
    .o_rdy  (bus.rdy_out),
    .i_data (w_tuple),
    .o_vld  (bus.vld_out),
    .i_rdy  (bus.rdy_in),
    .o_data (w_out)
  );

  assign bus.s_out      = w_out.s;
  assign bus.m_prev_out = w_out.m_prev;
  assign bus.v_out      = w_out.v;
  assign bus.first_out  = w_out.first;
  assign bus.last_out   = w_out.last;
  assign bus.row_done   = bus.vld_out && bus.rdy_in
                        && w_out.last;

endmodule
